// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag layout and FSM encoding for the ALU sequencing front-end.
package alu_seq_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned FLGW = 4;
  localparam int unsigned CNTW = 4;

  localparam logic [OPW-1:0] OP_ROL       = 4'd0;
  localparam logic [OPW-1:0] OP_ROR       = 4'd1;
  localparam logic [OPW-1:0] OP_MAX       = 4'd2;
  localparam logic [OPW-1:0] OP_MIN       = 4'd3;
  localparam logic [OPW-1:0] OP_DIV       = 4'd4;
  localparam logic [OPW-1:0] OP_SGE       = 4'd5;
  localparam logic [OPW-1:0] OP_OR        = 4'd6;
  localparam logic [OPW-1:0] OP_SGT       = 4'd7;
  localparam logic [OPW-1:0] OP_LEGAL_MAX = 4'd7;

  localparam int unsigned FLG_CARRY = 3;
  localparam int unsigned FLG_ZERO  = 2;
  localparam int unsigned FLG_OVF   = 1;
  localparam int unsigned FLG_SIGN  = 0;

  // Field order matches the FLG_* bit indices.
  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic sign;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [OPW-1:0] op);
    return op <= OP_LEGAL_MAX;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request, response and ALU-side signal bundle; master = issue/consumer/ALU side, slave = sequencer.
interface alu_seq_ctrl_if #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned SHW   = 5,
  parameter int unsigned TAGW  = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_opcode;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [SHW-1:0]   req0_shamt;
  logic [TAGW-1:0]  req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_opcode;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [SHW-1:0]   req1_shamt;
  logic [TAGW-1:0]  req1_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [3:0]       rsp_flags;
  logic             rsp_src;
  logic [TAGW-1:0]  rsp_tag;
  logic             rsp_err;

  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [SHW-1:0]   alu_shift;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_ovf;
  logic             alu_sign;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b, req0_shamt, req0_tag,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_a, req1_b, req1_shamt, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_result, rsp_flags, rsp_src, rsp_tag, rsp_err,
    input  rsp_ready,
    output alu_opcode, alu_in1, alu_in2, alu_shift,
    input  alu_result, alu_carry, alu_zero, alu_ovf, alu_sign
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b, req0_shamt, req0_tag,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_a, req1_b, req1_shamt, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_result, rsp_flags, rsp_src, rsp_tag, rsp_err,
    output rsp_ready,
    input  alu_opcode, alu_in1, alu_in2, alu_shift,
    output alu_result, alu_carry, alu_zero, alu_ovf, alu_sign
  );
endinterface

// File: rtl/alu_rr_arb2.sv
// Two-input round-robin arbiter: combinational one-hot grant, pointer flips to the loser on contention.
module alu_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11: begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
        if (advance_i) ptr_d = ~ptr_q;
      end
      default: gnt_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Arbitrates two requesters onto one shared ALU, holds operands for an op-dependent time, registers the response.
// Optional ALU_SEQ_STATS_EN adds saturating handshake/error counters (stat_ops, stat_err).
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 128,
  parameter int unsigned SHW      = 5,
  parameter int unsigned TAGW     = 4,
  parameter int unsigned DIV_LAT  = 4,
  parameter int unsigned BASE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_seq_ctrl_if.slave     bus,
  output logic              busy
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [15:0]       stat_err
`endif
);

  state_e           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [3:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
  logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
  logic [SHW-1:0]   alu_sh_q, alu_sh_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  flags_t           rsp_flags_q, rsp_flags_d;
  logic             rsp_src_q, rsp_src_d;
  logic [TAGW-1:0]  rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  logic [1:0]       gnt;
  logic             idle;
  logic             gsel;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [SHW-1:0]   sel_sh;
  logic [TAGW-1:0]  sel_tag;

  assign idle = (state_q == ST_IDLE);
  assign gsel = gnt[1];

  alu_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({bus.req1_valid, bus.req0_valid}),
    .advance_i (idle),
    .gnt_o     (gnt)
  );

  // Granted requester's command fields.
  always_comb begin
    sel_op  = gsel ? bus.req1_opcode : bus.req0_opcode;
    sel_a   = gsel ? bus.req1_a      : bus.req0_a;
    sel_b   = gsel ? bus.req1_b      : bus.req0_b;
    sel_sh  = gsel ? bus.req1_shamt  : bus.req0_shamt;
    sel_tag = gsel ? bus.req1_tag    : bus.req0_tag;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_op_d     = alu_op_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_sh_d     = alu_sh_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_src_d    = rsp_src_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          rsp_src_d = gsel;
          rsp_tag_d = sel_tag;
          if (op_legal(sel_op)) begin
            alu_op_d  = sel_op;
            alu_in1_d = sel_a;
            alu_in2_d = sel_b;
            alu_sh_d  = sel_sh;
            cnt_d     = (sel_op == OP_DIV) ? CNTW'(DIV_LAT - 1) : CNTW'(BASE_LAT - 1);
            state_d   = ST_HOLD;
          end else begin
            // Illegal ops never reach the ALU; answer immediately with an error.
            rsp_err_d    = 1'b1;
            rsp_result_d = '0;
            rsp_flags_d  = '0;
            rsp_valid_d  = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNTW'(1);
        end else begin
          rsp_result_d = bus.alu_result;
          rsp_flags_d  = '{carry: bus.alu_carry, zero: bus.alu_zero,
                           ovf: bus.alu_ovf, sign: bus.alu_sign};
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_op_q     <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_sh_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_src_q    <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_op_q     <= alu_op_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_sh_q     <= alu_sh_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_src_q    <= rsp_src_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign bus.req0_ready = idle & gnt[0];
  assign bus.req1_ready = idle & gnt[1];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_src    = rsp_src_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.alu_shift  = alu_sh_q;
  assign busy           = ~idle;

`ifdef ALU_SEQ_STATS_EN
  logic [31:0] stat_ops_q;
  logic [15:0] stat_err_q;
  logic        hs;

  assign hs = (state_q == ST_RESP) & bus.rsp_ready;

  // Saturating counters of completed response handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_err_q <= '0;
    end else if (hs) begin
      if (stat_ops_q != '1)              stat_ops_q <= stat_ops_q + 32'd1;
      if (rsp_err_q && stat_err_q != '1) stat_err_q <= stat_err_q + 16'd1;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_err = stat_err_q;
`endif

endmodule
